// File: rtl/frame_sequencer_pkg.sv
// Shared encodings and widths for the per-frame sequencer and its watchdog.
package frame_sequencer_pkg;

    localparam int POS_X_W  = 14;
    localparam int POS_Y_W  = 13;
    localparam int ANGLE_W  = 8;
    localparam int GRID_X_W = 6;
    localparam int GRID_Y_W = 5;
    localparam int WD_W     = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPD    = 2'd1,
        COMMIT = 2'd2,
        RND    = 2'd3
    } state_t;

endpackage

// File: rtl/frame_watchdog.sv
// Load-clear cycle counter with terminal-count compare. The same instance
// guards both wait states: the sequencer clears it on every state change,
// so the count always measures time spent in the current state.
module frame_watchdog
    import frame_sequencer_pkg::*;
#(
    parameter logic [WD_W-1:0] LIMIT = 20'd800000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Last count value that still belongs to the allowed window, so the
    // state is held for exactly LIMIT cycles before the abort.
    localparam logic [WD_W-1:0] TERMINAL = LIMIT - WD_W'(1);

    logic [WD_W-1:0] count;

    // Count cycles while enabled; a clear wins so a fresh state starts at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WD_W'(1);
        end
    end

    // Compare happens before the count could ever reach the wrap point.
    always_comb begin
        expired = enable && (count == TERMINAL);
    end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: on each frame tick runs the player updater, commits
// its result into the player state registers, then runs the renderer. Owns
// the single map-grid read port and steers it to whichever client is active.
//
// Handshake: upd_start / rnd_start are one-cycle registered pulses, high in
// the first cycle of UPD / RND. The matching done input (level or pulse) is
// accepted in any later cycle of that state; it is ignored while the start
// pulse is high so a done level left over from the previous frame is never
// mistaken for completion of the new request.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter logic [POS_X_W-1:0] INIT_POS_X = 14'd1024,
    parameter logic [POS_Y_W-1:0] INIT_POS_Y = 13'd1024,
    parameter logic [ANGLE_W-1:0] INIT_ANGLE = 8'd0,
    parameter logic [WD_W-1:0]    TIMEOUT    = 20'd800000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_tick,
    output logic                upd_start,
    input  logic                upd_done,
    input  logic [POS_X_W-1:0]  upd_next_pos_x,
    input  logic [POS_Y_W-1:0]  upd_next_pos_y,
    input  logic [ANGLE_W-1:0]  upd_next_angle,
    output logic                rnd_start,
    input  logic                rnd_done,
    output logic [POS_X_W-1:0]  cur_pos_x,
    output logic [POS_Y_W-1:0]  cur_pos_y,
    output logic [ANGLE_W-1:0]  cur_angle,
    input  logic [GRID_X_W-1:0] upd_grid_x,
    input  logic [GRID_Y_W-1:0] upd_grid_y,
    input  logic [GRID_X_W-1:0] rnd_grid_x,
    input  logic [GRID_Y_W-1:0] rnd_grid_y,
    output logic [GRID_X_W-1:0] grid_x,
    output logic [GRID_Y_W-1:0] grid_y,
    output logic                busy,
    output logic [15:0]         frame_count,
    output logic [7:0]          overrun_count,
    output logic                timeout_err,
    output logic [1:0]          state_dbg
);

    state_t state;
    state_t state_next;

    logic upd_done_seen;
    logic rnd_done_seen;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    logic start_upd;
    logic start_rnd;
    logic commit;
    logic frame_done;
    logic abort;

    assign upd_done_seen = upd_done && !upd_start;
    assign rnd_done_seen = rnd_done && !rnd_start;
    assign wd_enable     = (state == UPD) || (state == RND);
    assign wd_clear      = (state_next != state);

    frame_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // Next-state and per-cycle action decode; completion beats timeout.
    always_comb begin
        state_next = state;
        start_upd  = 1'b0;
        start_rnd  = 1'b0;
        commit     = 1'b0;
        frame_done = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_next = UPD;
                    start_upd  = 1'b1;
                end
            end
            UPD: begin
                if (upd_done_seen) begin
                    state_next = COMMIT;
                end else if (wd_expired) begin
                    state_next = RND;
                    start_rnd  = 1'b1;
                    abort      = 1'b1;
                end
            end
            COMMIT: begin
                state_next = RND;
                start_rnd  = 1'b1;
                commit     = 1'b1;
            end
            RND: begin
                if (rnd_done_seen) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end else if (wd_expired) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered start pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            upd_start <= 1'b0;
            rnd_start <= 1'b0;
        end else begin
            state     <= state_next;
            upd_start <= start_upd;
            rnd_start <= start_rnd;
        end
    end

    // Committed player state: only COMMIT loads it, so it is stable in RND.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_pos_x <= INIT_POS_X;
            cur_pos_y <= INIT_POS_Y;
            cur_angle <= INIT_ANGLE;
        end else if (commit) begin
            cur_pos_x <= upd_next_pos_x;
            cur_pos_y <= upd_next_pos_y;
            cur_angle <= upd_next_angle;
        end
    end

    // Frame / overrun statistics and the sticky watchdog flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count   <= '0;
            overrun_count <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (frame_done) begin
                frame_count <= frame_count + 16'd1;
            end
            if (frame_tick && (state != IDLE) && (overrun_count != 8'hFF)) begin
                overrun_count <= overrun_count + 8'd1;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Map-port steering from the registered state: the updater owns it only in UPD.
    always_comb begin
        if (state == UPD) begin
            grid_x = upd_grid_x;
            grid_y = upd_grid_y;
        end else begin
            grid_x = rnd_grid_x;
            grid_y = rnd_grid_y;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: table-driven frame sequences plus
// hand-written sequences for timeout, overrun saturation and mid-frame reset.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam logic [19:0] TB_TIMEOUT = 20'd100;

    logic        clock;
    logic        reset;
    logic        frame_tick;
    logic        upd_start;
    logic        upd_done;
    logic [13:0] upd_next_pos_x;
    logic [12:0] upd_next_pos_y;
    logic [7:0]  upd_next_angle;
    logic        rnd_start;
    logic        rnd_done;
    logic [13:0] cur_pos_x;
    logic [12:0] cur_pos_y;
    logic [7:0]  cur_angle;
    logic [5:0]  upd_grid_x;
    logic [4:0]  upd_grid_y;
    logic [5:0]  rnd_grid_x;
    logic [4:0]  rnd_grid_y;
    logic [5:0]  grid_x;
    logic [4:0]  grid_y;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    frame_sequencer #(
        .INIT_POS_X(14'd1024),
        .INIT_POS_Y(13'd1024),
        .INIT_ANGLE(8'd0),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .upd_start     (upd_start),
        .upd_done      (upd_done),
        .upd_next_pos_x(upd_next_pos_x),
        .upd_next_pos_y(upd_next_pos_y),
        .upd_next_angle(upd_next_angle),
        .rnd_start     (rnd_start),
        .rnd_done      (rnd_done),
        .cur_pos_x     (cur_pos_x),
        .cur_pos_y     (cur_pos_y),
        .cur_angle     (cur_angle),
        .upd_grid_x    (upd_grid_x),
        .upd_grid_y    (upd_grid_y),
        .rnd_grid_x    (rnd_grid_x),
        .rnd_grid_y    (rnd_grid_y),
        .grid_x        (grid_x),
        .grid_y        (grid_y),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count),
        .timeout_err   (timeout_err),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ft;
        logic        ud;
        logic        rd;
        logic [1:0]  st;
        logic        us;
        logic        rs;
        logic [15:0] fc;
        logic [13:0] px;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic void add(input logic ft, input logic ud, input logic rd,
                                input logic [1:0] st, input logic us, input logic rs,
                                input logic [15:0] fc, input logic [13:0] px);
        vec_t v;
        v.ft = ft; v.ud = ud; v.rd = rd;
        v.st = st; v.us = us; v.rs = rs; v.fc = fc; v.px = px;
        vecs.push_back(v);
    endfunction

    // Each row: inputs held for one cycle, outputs checked after that edge.
    task automatic run_vecs(input string tag);
        logic [5:0] exp_gx;
        logic [4:0] exp_gy;
        foreach (vecs[i]) begin
            frame_tick = vecs[i].ft;
            upd_done   = vecs[i].ud;
            rnd_done   = vecs[i].rd;
            step();
            exp_gx = (vecs[i].st == 2'd1) ? 6'd5 : 6'd40;
            exp_gy = (vecs[i].st == 2'd1) ? 5'd7 : 5'd20;
            check($sformatf("%s[%0d] state", tag, i), state_dbg, vecs[i].st);
            check($sformatf("%s[%0d] upd_start", tag, i), upd_start, vecs[i].us);
            check($sformatf("%s[%0d] rnd_start", tag, i), rnd_start, vecs[i].rs);
            check($sformatf("%s[%0d] busy", tag, i), busy, (vecs[i].st != 2'd0));
            check($sformatf("%s[%0d] frame_count", tag, i), frame_count, vecs[i].fc);
            check($sformatf("%s[%0d] cur_pos_x", tag, i), cur_pos_x, vecs[i].px);
            check($sformatf("%s[%0d] grid_x", tag, i), grid_x, exp_gx);
            check($sformatf("%s[%0d] grid_y", tag, i), grid_y, exp_gy);
        end
        vecs.delete();
        frame_tick = 1'b0;
        upd_done   = 1'b0;
        rnd_done   = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        reset          = 1'b1;
        frame_tick     = 1'b0;
        upd_done       = 1'b0;
        rnd_done       = 1'b0;
        upd_next_pos_x = 14'd2000;
        upd_next_pos_y = 13'd1500;
        upd_next_angle = 8'd64;
        upd_grid_x     = 6'd5;
        upd_grid_y     = 5'd7;
        rnd_grid_x     = 6'd40;
        rnd_grid_y     = 5'd20;
        step();
        step();
        check("rst state", state_dbg, 2'd0);
        check("rst cur_pos_x", cur_pos_x, 14'd1024);
        check("rst cur_pos_y", cur_pos_y, 13'd1024);
        check("rst cur_angle", cur_angle, 8'd0);
        check("rst starts", {upd_start, rnd_start}, 2'b00);
        check("rst counters", {frame_count, overrun_count, timeout_err}, 25'd0);
        check("rst grid_x", grid_x, 6'd40);
        reset = 1'b0;
        step();
        check("idle busy", busy, 1'b0);

        // Basic frame: done after 10 UPD cycles, render done after 50 RND cycles.
        add(1, 0, 0, UPD, 1, 0, 0, 14'd1024);
        for (int i = 1; i < 10; i++) add(0, 0, 0, UPD, 0, 0, 0, 14'd1024);
        add(0, 1, 0, COMMIT, 0, 0, 0, 14'd1024);
        add(0, 0, 0, RND, 0, 1, 0, 14'd2000);
        for (int i = 1; i < 50; i++) add(0, 0, 0, RND, 0, 0, 0, 14'd2000);
        add(0, 0, 1, IDLE, 0, 0, 1, 14'd2000);
        add(0, 0, 0, IDLE, 0, 0, 1, 14'd2000);
        run_vecs("frame1");
        check("frame1 cur_pos_y", cur_pos_y, 13'd1500);
        check("frame1 cur_angle", cur_angle, 8'd64);
        check("frame1 overrun", overrun_count, 8'd0);

        // Level-held done signals: first cycle of each wait state ignores them.
        upd_next_pos_x = 14'd3000;
        upd_next_pos_y = 13'd1600;
        upd_next_angle = 8'd128;
        upd_done = 1'b1;
        step();
        check("level idle stays", state_dbg, 2'd0);
        add(1, 1, 0, UPD, 1, 0, 1, 14'd2000);
        add(0, 1, 0, UPD, 0, 0, 1, 14'd2000);
        add(0, 1, 0, COMMIT, 0, 0, 1, 14'd2000);
        add(0, 0, 0, RND, 0, 1, 1, 14'd3000);
        add(0, 0, 1, RND, 0, 0, 1, 14'd3000);
        add(0, 0, 1, IDLE, 0, 0, 2, 14'd3000);
        run_vecs("level");
        check("level cur_angle", cur_angle, 8'd128);

        // Three ticks during RND, the last one in the exit cycle.
        add(1, 0, 0, UPD, 1, 0, 2, 14'd3000);
        add(0, 0, 0, UPD, 0, 0, 2, 14'd3000);
        add(0, 1, 0, COMMIT, 0, 0, 2, 14'd3000);
        add(0, 0, 0, RND, 0, 1, 2, 14'd3000);
        add(1, 0, 0, RND, 0, 0, 2, 14'd3000);
        add(1, 0, 0, RND, 0, 0, 2, 14'd3000);
        add(1, 0, 1, IDLE, 0, 0, 3, 14'd3000);
        add(0, 0, 0, IDLE, 0, 0, 3, 14'd3000);
        run_vecs("overrun");
        check("overrun count 3", overrun_count, 8'd3);
        check("overrun no timeout", timeout_err, 1'b0);

        // Updater never finishes: exactly TIMEOUT cycles in UPD, no commit.
        upd_next_pos_x = 14'd111;
        upd_next_pos_y = 13'd222;
        upd_next_angle = 8'd33;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n = 0;
        while (state_dbg == 2'd1 && n < 400) begin
            n++;
            step();
        end
        check("timeout upd cycles", n, 100);
        check("timeout state rnd", state_dbg, 2'd3);
        check("timeout rnd_start", rnd_start, 1'b1);
        check("timeout err", timeout_err, 1'b1);
        check("timeout cur_pos_x", cur_pos_x, 14'd3000);
        check("timeout cur_pos_y", cur_pos_y, 13'd1600);
        check("timeout cur_angle", cur_angle, 8'd128);
        rnd_done = 1'b1;
        step();
        check("timeout rnd 2nd", {state_dbg, rnd_start}, 3'b110);
        step();
        rnd_done = 1'b0;
        check("timeout frame idle", state_dbg, 2'd0);
        check("timeout frame_count", frame_count, 16'd4);

        // Continuous ticks: overrun counter saturates.
        frame_tick = 1'b1;
        for (int i = 0; i < 300; i++) step();
        frame_tick = 1'b0;
        check("overrun saturate", overrun_count, 8'd255);
        n = 0;
        while (busy && n < 400) begin
            n++;
            step();
        end
        check("drain to idle", busy, 1'b0);
        check("err sticky", timeout_err, 1'b1);

        // Reset in the middle of RND.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        upd_done = 1'b1;
        step();
        upd_done = 1'b0;
        step();
        step();
        check("pre-reset state rnd", state_dbg, 2'd3);
        check("pre-reset cur_pos_x", cur_pos_x, 14'd111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst state", state_dbg, 2'd0);
        check("midrst cur_pos_x", cur_pos_x, 14'd1024);
        check("midrst cur_pos_y", cur_pos_y, 13'd1024);
        check("midrst cur_angle", cur_angle, 8'd0);
        check("midrst counters", {frame_count, overrun_count, timeout_err}, 25'd0);
        check("midrst starts", {upd_start, rnd_start}, 2'b00);
        step();
        check("midrst stays idle", {state_dbg, upd_start, rnd_start}, 4'b0000);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("clean start state", state_dbg, 2'd1);
        check("clean start pulse", upd_start, 1'b1);
        step();
        upd_done = 1'b1;
        step();
        upd_done = 1'b0;
        check("clean commit", state_dbg, 2'd2);
        step();
        check("clean cur_pos_x", cur_pos_x, 14'd111);
        rnd_done = 1'b1;
        step();
        step();
        rnd_done = 1'b0;
        check("clean frame_count", frame_count, 16'd1);
        check("clean idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
